plic_core: RTL and testbench

//  Parametrised PLIC target core: IRQ_NUM sources (source 0 hard-wired to 0).
//  Per-source gateway FSM with level/edge mode, priority, enable, threshold and claim/complete.

---
 rtl/plic_core.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_plic_core.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/plic_core.sv
// ---------------------------------------------------------------------------
// plic_core
//
// Platform-level interrupt controller core for a single hart context.
// IRQ_NUM interrupt sources are supported, and source 0 is hard-wired inactive.
// Each source has a gateway (IDLE / PEND / SERV) that can run in level or edge
// mode. Each source also has a priority and an enable bit. One global
// threshold is shared by all sources. Interrupts are taken through the
// claim/complete protocol, and the core drives one registered external
// interrupt line.
//
// Register port protocol: reg_we_i and reg_re_i are single-cycle strobes with
// no back-pressure. The port is always ready. A write takes effect at the
// clock edge where reg_we_i is sampled high. A read strobe sampled at an edge
// loads reg_rdata_o at that same edge, so the data is valid during the
// following cycle. The two strobes are never high together.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   irq_i        raw interrupt sources (bit 0 ignored)
//   reg_we_i     register write strobe
//   reg_re_i     register read strobe (a read of CLAIM claims)
//   reg_addr_i   word index
//   reg_wdata_i  write data
//   reg_rdata_o  read data, valid the cycle after reg_re_i
//   ext_irq_o    registered interrupt request to the hart
//
// Word map
//   0x00+i PRIO[i]   0x40 IP (RO)   0x41 IE   0x42 THOLD
//   0x43   CLAIM (read) / COMPLETE (write)    0x44 MODE (1 = edge)
// ---------------------------------------------------------------------------
module plic_core #(
    parameter int IRQ_NUM        = 32,
    parameter int IRQ_PRIO_WIDTH = 3,
    parameter int ID_WIDTH       = $clog2(IRQ_NUM)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IRQ_NUM-1:0] irq_i,
    input  logic               reg_we_i,
    input  logic               reg_re_i,
    input  logic [7:0]         reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [31:0]        reg_rdata_o,
    output logic               ext_irq_o
);

    localparam logic [7:0] ADDR_IP    = 8'h40;
    localparam logic [7:0] ADDR_IE    = 8'h41;
    localparam logic [7:0] ADDR_THOLD = 8'h42;
    localparam logic [7:0] ADDR_CLAIM = 8'h43;
    localparam logic [7:0] ADDR_MODE  = 8'h44;
    localparam logic [7:0] PRIO_LAST  = 8'(IRQ_NUM - 1);

    // Source 0 is forced low here, so its gateway can never leave IDLE.
    localparam logic [IRQ_NUM-1:0] SRC_MASK = {{(IRQ_NUM-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        GW_IDLE = 2'd0,
        GW_PEND = 2'd1,
        GW_SERV = 2'd2
    } gw_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    gw_state_t                 gw_q [IRQ_NUM];
    gw_state_t                 gw_d [IRQ_NUM];
    logic [IRQ_NUM-1:0]        edge_seen_q;
    logic [IRQ_NUM-1:0]        edge_seen_d;
    logic [IRQ_NUM-1:0]        irq_src;
    logic [IRQ_NUM-1:0]        irq_q;
    logic [IRQ_NUM-1:0]        rise_q;

    logic [IRQ_PRIO_WIDTH-1:0] prio_q [IRQ_NUM];
    logic [IRQ_NUM-1:0]        ie_q;
    logic [IRQ_NUM-1:0]        mode_q;
    logic [IRQ_PRIO_WIDTH-1:0] thold_q;

    logic [ID_WIDTH-1:0]       max_id_q;
    logic [IRQ_PRIO_WIDTH-1:0] max_prio_q;
    logic                      max_valid_q;

    // ------------------------------------------------------------------
    // Register port decode
    // ------------------------------------------------------------------
    logic                      prio_sel;
    logic [ID_WIDTH-1:0]       prio_idx;
    logic                      claim_rd;
    logic                      claim_ok;
    logic                      claim_fire;
    logic                      cpl_wr;
    logic [ID_WIDTH-1:0]       cpl_id;

    assign irq_src    = irq_i & SRC_MASK;
    assign prio_sel   = (reg_addr_i <= PRIO_LAST);
    assign prio_idx   = reg_addr_i[ID_WIDTH-1:0];
    assign claim_rd   = reg_re_i && (reg_addr_i == ADDR_CLAIM);
    // Claims use the registered winner, so a PRIO or IE write in the same
    // cycle cannot affect which ID is returned.
    assign claim_ok   = max_valid_q && (max_prio_q > thold_q);
    assign claim_fire = claim_rd && claim_ok;
    assign cpl_wr     = reg_we_i && (reg_addr_i == ADDR_CLAIM);
    assign cpl_id     = reg_wdata_i[ID_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Edge detector. The rising edge is registered once. This adds one
    // cycle of latency in edge mode compared with level mode.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q  <= '0;
            rise_q <= '0;
        end else begin
            irq_q  <= irq_src;
            rise_q <= irq_src & ~irq_q;
        end
    end

    // ------------------------------------------------------------------
    // Gateway FSMs: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < IRQ_NUM; i++) begin
                gw_q[i] <= GW_IDLE;
            end
            edge_seen_q <= '0;
        end else begin
            for (int i = 0; i < IRQ_NUM; i++) begin
                gw_q[i] <= gw_d[i];
            end
            edge_seen_q <= edge_seen_d;
        end
    end

    // ------------------------------------------------------------------
    // Gateway FSMs: next state
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < IRQ_NUM; i++) begin
            gw_d[i]        = gw_q[i];
            edge_seen_d[i] = edge_seen_q[i];
        end
        for (int i = 0; i < IRQ_NUM; i++) begin
            case (gw_q[i])
                GW_IDLE: begin
                    if (mode_q[i] ? rise_q[i] : irq_src[i]) begin
                        gw_d[i] = GW_PEND;
                    end
                end
                GW_PEND: begin
                    if (claim_fire && (max_id_q == ID_WIDTH'(i))) begin
                        gw_d[i] = GW_SERV;
                    end
                    if (mode_q[i] && rise_q[i]) begin
                        edge_seen_d[i] = 1'b1;
                    end
                end
                GW_SERV: begin
                    if (cpl_wr && (cpl_id == ID_WIDTH'(i))) begin
                        // An edge that arrives in the completion cycle
                        // counts as remembered, so it is not lost.
                        if (mode_q[i] && (edge_seen_q[i] || rise_q[i])) begin
                            gw_d[i] = GW_PEND;
                        end else begin
                            gw_d[i] = GW_IDLE;
                        end
                        edge_seen_d[i] = 1'b0;
                    end else if (mode_q[i] && rise_q[i]) begin
                        edge_seen_d[i] = 1'b1;
                    end
                end
                default: begin
                    gw_d[i] = GW_IDLE;
                end
            endcase
            // edge_seen is used only in edge mode. It is kept clear in
            // level mode so a later mode switch starts from a clean state.
            if (!mode_q[i]) begin
                edge_seen_d[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < IRQ_NUM; i++) begin
                prio_q[i] <= '0;
            end
            ie_q    <= '0;
            mode_q  <= '0;
            thold_q <= '0;
        end else if (reg_we_i) begin
            if (prio_sel) begin
                for (int i = 1; i < IRQ_NUM; i++) begin
                    if (prio_idx == ID_WIDTH'(i)) begin
                        prio_q[i] <= reg_wdata_i[IRQ_PRIO_WIDTH-1:0];
                    end
                end
            end
            if (reg_addr_i == ADDR_IE) begin
                ie_q <= {reg_wdata_i[IRQ_NUM-1:1], 1'b0};
            end
            if (reg_addr_i == ADDR_MODE) begin
                mode_q <= {reg_wdata_i[IRQ_NUM-1:1], 1'b0};
            end
            if (reg_addr_i == ADDR_THOLD) begin
                thold_q <= reg_wdata_i[IRQ_PRIO_WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration. A strict '>' keeps the first, lowest-ID source when
    // priorities tie. Priority 0 never beats the initial zero, so it can
    // never be selected.
    // ------------------------------------------------------------------
    logic [ID_WIDTH-1:0]       arb_id;
    logic [IRQ_PRIO_WIDTH-1:0] arb_prio;
    logic                      arb_valid;
    logic [IRQ_NUM-1:0]        ip_vec;

    always_comb begin
        arb_id   = '0;
        arb_prio = '0;
        ip_vec   = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            ip_vec[i] = (gw_q[i] == GW_PEND);
            if (ip_vec[i] && ie_q[i] && (prio_q[i] > arb_prio)) begin
                arb_id   = ID_WIDTH'(i);
                arb_prio = prio_q[i];
            end
        end
        arb_valid = (arb_prio != '0);
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        if (prio_sel) begin
            rd_val = 32'(prio_q[prio_idx]);
        end else if (reg_addr_i == ADDR_IP) begin
            rd_val = 32'(ip_vec);
        end else if (reg_addr_i == ADDR_IE) begin
            rd_val = 32'(ie_q);
        end else if (reg_addr_i == ADDR_THOLD) begin
            rd_val = 32'(thold_q);
        end else if (reg_addr_i == ADDR_CLAIM) begin
            rd_val = claim_ok ? 32'(max_id_q) : 32'd0;
        end else if (reg_addr_i == ADDR_MODE) begin
            rd_val = 32'(mode_q);
        end
    end

    // ------------------------------------------------------------------
    // Winner pipeline, read data and interrupt output
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            max_id_q    <= '0;
            max_prio_q  <= '0;
            max_valid_q <= 1'b0;
            reg_rdata_o <= '0;
            ext_irq_o   <= 1'b0;
        end else begin
            max_id_q    <= arb_id;
            max_prio_q  <= arb_prio;
            // During a claim, arbitration still sees the claimed gateway as
            // PEND. The winner is therefore dropped for one cycle so that a
            // following claim cannot return the same ID.
            max_valid_q <= claim_rd ? 1'b0 : arb_valid;
            reg_rdata_o <= reg_re_i ? rd_val : 32'd0;
            ext_irq_o   <= max_valid_q && (max_prio_q > thold_q);
        end
    end

endmodule

// File: tb/tb_plic_core.sv
module tb_plic_core;

  localparam int IRQ_NUM = 32;

  localparam logic [7:0] A_IP    = 8'h40;
  localparam logic [7:0] A_IE    = 8'h41;
  localparam logic [7:0] A_TH    = 8'h42;
  localparam logic [7:0] A_CLM   = 8'h43;
  localparam logic [7:0] A_MODE  = 8'h44;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic [IRQ_NUM-1:0] irq;
  logic               reg_we;
  logic               reg_re;
  logic [7:0]         reg_addr;
  logic [31:0]        reg_wdata;
  logic [31:0]        reg_rdata;
  logic               ext_irq;

  always #5 clk = ~clk;

  plic_core #(.IRQ_NUM(IRQ_NUM), .IRQ_PRIO_WIDTH(3)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .irq_i       (irq),
    .reg_we_i    (reg_we),
    .reg_re_i    (reg_re),
    .reg_addr_i  (reg_addr),
    .reg_wdata_i (reg_wdata),
    .reg_rdata_o (reg_rdata),
    .ext_irq_o   (ext_irq)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input int idx, input logic [31:0] act);
    logic [31:0] exp_v;
    exp_v = exp_q.pop_front();
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp_v);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drv_wr(input logic [7:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
  endtask

  task automatic drv_rd(input logic [7:0] a, output logic [31:0] d);
    reg_re = 1'b1; reg_addr = a;
    @(negedge clk);
    reg_re = 1'b0; reg_addr = '0;
    d = reg_rdata;
  endtask

  task automatic drv_irq(input logic [31:0] d);
    irq = d[IRQ_NUM-1:0];
    @(negedge clk);
  endtask

  task automatic drv_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef enum logic [1:0] {V_WR, V_RD, V_IRQ, V_WAIT} vkind_t;
  typedef struct {
    vkind_t      kind;
    logic [7:0]  addr;
    logic [31:0] data;   // write data, irq vector, or wait cycles
    logic [31:0] exp;    // expected read data or ext_irq_o
  } vec_t;

  vec_t vecs[$];

  function automatic void wr(input logic [7:0] a, input logic [31:0] d);
    vecs.push_back('{V_WR, a, d, 32'd0});
  endfunction
  function automatic void rd(input logic [7:0] a, input logic [31:0] e);
    vecs.push_back('{V_RD, a, 32'd0, e});
  endfunction
  function automatic void pin(input logic [31:0] d);
    vecs.push_back('{V_IRQ, 8'd0, d, 32'd0});
  endfunction
  function automatic void wt(input int n, input logic [31:0] e);
    vecs.push_back('{V_WAIT, 8'd0, 32'(n), e});
  endfunction

  task automatic run_vectors();
    logic [31:0] r;
    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].kind)
        V_WR:  drv_wr(vecs[i].addr, vecs[i].data);
        V_IRQ: drv_irq(vecs[i].data);
        V_RD: begin
          drv_rd(vecs[i].addr, r);
          exp_q.push_back(vecs[i].exp);
          check("rdata", i, r);
        end
        default: begin
          drv_wait(int'(vecs[i].data));
          exp_q.push_back(vecs[i].exp);
          check("ext_irq", i, 32'(ext_irq));
        end
      endcase
    end
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; irq = '0; reg_we = 1'b0; reg_re = 1'b0;
    reg_addr = '0; reg_wdata = '0;
    repeat (2) @(negedge clk);
    exp_q.push_back(32'd0); check("reset_ext_irq", 0, 32'(ext_irq));
    exp_q.push_back(32'd0); check("reset_rdata", 0, reg_rdata);
    rst = 1'b0;
    @(negedge clk);

    // reset values
    rd(8'd3, 0); rd(A_IE, 0); rd(A_TH, 0); rd(A_MODE, 0); rd(A_IP, 0);
    wt(1, 0);

    // 1: level source 3, latency 3, claim, re-pend on complete
    wr(8'd3, 2); wr(A_IE, 32'h8);
    pin(32'h8); wt(1, 0); wt(1, 1);
    rd(A_IP, 32'h8);
    rd(A_CLM, 3);
    rd(A_IP, 0);
    wt(1, 0);
    wr(A_CLM, 3);
    wt(1, 0); wt(1, 0); wt(1, 1);
    rd(A_CLM, 3);
    pin(0); wr(A_CLM, 3);
    wt(3, 0); rd(A_IP, 0);

    // 2: tie goes to lowest ID, then higher priority wins
    wr(8'd2, 4); wr(8'd5, 4); wr(A_IE, 32'h24);
    pin(32'h24); wt(3, 1);
    rd(A_CLM, 2); wt(2, 1); rd(A_CLM, 5);
    pin(0); wr(A_CLM, 2); wr(A_CLM, 5);
    wr(8'd5, 6);
    pin(32'h24); wt(3, 1);
    rd(A_CLM, 5); wt(2, 1); rd(A_CLM, 2);
    pin(0); wr(A_CLM, 5); wr(A_CLM, 2);
    wt(3, 0);

    // 3: threshold equal to priority masks, lower threshold unmasks
    wr(A_TH, 4); wr(8'd7, 4); wr(A_IE, 32'h80);
    pin(32'h80); wt(4, 0);
    rd(A_CLM, 0);
    wr(A_TH, 3); wt(3, 1);
    rd(A_CLM, 7);
    pin(0); wr(A_CLM, 7); wr(A_TH, 0);
    rd(A_IP, 0);

    // 4: edge source 1, latency 4, edges while SERV are remembered once
    wr(8'd1, 1); wr(A_MODE, 32'h2); wr(A_IE, 32'h2);
    pin(32'h2); wt(2, 0); wt(1, 1);
    pin(0);
    rd(A_CLM, 1);
    pin(32'h2); pin(0); pin(32'h2); pin(0);
    wt(2, 0);
    wr(A_CLM, 1);
    rd(A_IP, 32'h2);
    wt(3, 1);
    rd(A_CLM, 1);
    wr(A_CLM, 1);
    rd(A_IP, 0);
    wt(3, 0);
    // edge arriving in the same cycle as the complete
    pin(32'h2); wt(3, 1);
    rd(A_CLM, 1);
    pin(0); pin(32'h2);
    wr(A_CLM, 1);
    rd(A_IP, 32'h2);
    rd(A_CLM, 1);
    pin(0); wr(A_CLM, 1);
    rd(A_IP, 0);

    // 5: ignored completes, unmapped accesses, field masking
    wr(A_CLM, 9); wr(A_CLM, 0); wr(8'h7F, 32'hFFFF_FFFF);
    rd(A_IP, 0); rd(8'h7F, 0); rd(8'h20, 0);
    rd(A_IE, 32'h2); rd(8'd1, 1); rd(A_TH, 0);
    wr(8'd0, 7); rd(8'd0, 0);
    wr(8'd6, 32'hFF); rd(8'd6, 7);
    wr(A_IE, 32'hFFFF_FFFF); rd(A_IE, 32'hFFFF_FFFE);
    wr(A_MODE, 32'hFFFF_FFFF); rd(A_MODE, 32'hFFFF_FFFE);
    wr(A_MODE, 0); wr(A_IE, 0);
    wt(3, 0);

    // 6 (setup): level source 4 taken into SERV
    wr(8'd4, 3); wr(A_IE, 32'h10);
    pin(32'h10); wt(3, 1);
    rd(A_CLM, 4);

    run_vectors();

    // 6: asynchronous reset while source 4 is in SERV
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(32'd0); check("midrst_ext_irq", 0, 32'(ext_irq));
    exp_q.push_back(32'd0); check("midrst_rdata", 0, reg_rdata);
    @(negedge clk);
    rst = 1'b0;
    drv_wait(1);
    exp_q.push_back(32'd0); check("post_rst_ext_irq", 0, 32'(ext_irq));
    drv_rd(A_IP, r);   exp_q.push_back(32'h10); check("post_rst_ip", 0, r);
    drv_rd(8'd4, r);   exp_q.push_back(32'd0);  check("post_rst_prio4", 0, r);
    drv_rd(A_IE, r);   exp_q.push_back(32'd0);  check("post_rst_ie", 0, r);
    drv_wait(3);
    exp_q.push_back(32'd0); check("post_rst_masked", 0, 32'(ext_irq));
    drv_wr(8'd4, 1);
    drv_wr(A_IE, 32'h10);
    drv_wait(3);
    exp_q.push_back(32'd1); check("post_rst_ext_irq_up", 0, 32'(ext_irq));
    drv_rd(A_CLM, r);  exp_q.push_back(32'd4); check("post_rst_claim", 0, r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
